shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit D-register, built as a bank of D-FFs.
- NREQ requesters compete for the register with a req/gnt/ack handshake.
- The winner's data is committed to the register one cycle after grant.
- Sits between local requesters and the shared storage; q is the register output, visible to all.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, width of the shared register and of each requester's write data.
- IW, clog2(NREQ), width of the owner index (derived; not user-set).

Ports:
- c  input  1  clock; all state changes on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; requester holds it high until it sees ack with gnt.
- wdata  input  NREQ*WIDTH  packed write data; slice i = wdata[i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, registered.
- ack  output  1  one-cycle pulse: the granted requester's data was committed.
- q  output  WIDTH  shared register contents.
- owner  output  IW  index of the last committed requester.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; gnt=0; ack=0; q=0; owner=0; busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Reset removed synchronously by the environment; no output glitches on release beyond the reset values.
- FSM states: IDLE, GRANT, DONE.
- IDLE:
  - If req!=0, pick winner w = first set req bit searching last+1, last+2, ... modulo NREQ.
  - At the edge: gnt<=onehot(w), sel<=w, state->GRANT.
  - Otherwise stay in IDLE.
- GRANT (gnt high for exactly one cycle):
  - If req[sel]=1 at the edge: q<=wdata[sel], owner<=sel, last<=sel, ack<=1, gnt<=0, state->DONE.
  - If req[sel]=0 at the edge (abort): gnt<=0, no write, ack stays 0, last unchanged, state->IDLE.
- DONE (ack high for exactly one cycle):
  - At the edge ack<=0.
  - Arbitration as in IDLE, excluding bit `last` from the request vector this cycle: the just-served requester may still show req while dropping it.
  - Any other request present: gnt<=onehot(w), state->GRANT. Otherwise state->IDLE.
- Throughput and latency:
  - Back-to-back commits every 2 cycles.
  - Latency from req sampled in IDLE to q update: 2 edges (E0 grant, E1 commit).
- gnt is never multi-hot; ack never coincides with gnt.
- q changes only on an ack-producing edge; q holds otherwise.
- Reset mid-operation (any state): immediate return to reset values; an in-flight grant is lost, no ack.
- req bits of non-granted requesters may toggle freely at any time; only req[sel] in GRANT matters.
- NREQ=1 is not supported (NREQ>=2).
- wdata slices of non-selected requesters are ignored.

Decomposition:
- Package shared_reg_arbiter_pkg holds the state enum (IDLE, GRANT, DONE), the clog2 helper and the owner index type.
- One combinational sub-module, rr_pick: inputs req vector, last pointer, mask enable; outputs winner index and valid.
  - Implemented by rotating the request vector, priority-encoding, and rotating back.
- The FSM, q register and pointer live in the top module.

Test Plan:
- Reset: drive req=0010, wdata slice1=0xA5; pull rstn low while in GRANT -> gnt=0000, ack=0, q=0x00, busy=0 immediately, before the next edge.
- Single request: req=0010, slice1=0xA5 from idle -> gnt=0010 after E0; after E1 q=0xA5, owner=1, ack=1 for one cycle; gnt=0000.
- Fairness: req=1111 held constantly, slices 0x10,0x11,0x12,0x13 -> grants 0,1,2,3,0 in order; ack every 2nd cycle; q sequence 0x10,0x11,0x12,0x13,0x10.
- Abort: req=0100 granted, then req2 dropped during GRANT -> no ack, q unchanged, last unchanged; a later req=0101 grants 0 first when last=3.
- Priority wrap: after a commit by requester 3, req=1001 asserted -> requester 0 granted first; requester 3 granted next only if still requesting.
- DONE masking: requester 1 keeps req high one cycle after its ack, with no other requests -> FSM returns to IDLE, then re-grants 1 (no double commit during DONE).

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter.
package shared_reg_arbiter_pkg;

  // Largest supported requester count is 16, so 4 bits cover any owner index.
  localparam int IDX_W_MAX = 4;

  typedef logic [IDX_W_MAX-1:0] idx_max_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2, used to size the owner index from NREQ.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin winner selection: rotate requests so the slot after `last`
// sits at bit 0, take the lowest set bit, then map the offset back to an index.
module shared_reg_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  input  logic            mask,
  output logic [IW-1:0]   win,
  output logic            valid
);

  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] rot;
  logic [IW:0]     shamt;
  int              w_int;

  // Drop the just-served requester when masking is requested.
  always_comb begin
    masked = req;
    for (int i = 0; i < NREQ; i++) begin
      if (mask && (last == IW'(i))) masked[i] = 1'b0;
    end
  end

  // Rotate right by last+1; shifting the doubled vector handles the wrap.
  always_comb begin
    shamt = {1'b0, last} + 1'b1;
    rot   = NREQ'({masked, masked} >> shamt);
  end

  // Lowest set bit of the rotated vector, translated back to a requester index.
  always_comb begin
    valid = 1'b0;
    win   = '0;
    w_int = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        w_int = int'(last) + 1 + k;
        if (w_int >= NREQ) w_int = w_int - NREQ;
        win = IW'(w_int);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared register.
//
//   state | meaning
//   IDLE  | no grant outstanding; arbitrate among all requests
//   GRANT | gnt[sel] high this cycle; commit if req[sel] still high
//   DONE  | ack high this cycle; arbitrate excluding the just-served requester
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IW    = clog2(NREQ)
) (
  input  logic                  c,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic [WIDTH-1:0]      q,
  output logic [IW-1:0]         owner,
  output logic                  busy
);

  state_t           state;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    last;
  logic [IW-1:0]    pick_win;
  logic             pick_valid;
  logic             sel_req;
  logic [WIDTH-1:0] sel_data;

  shared_reg_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (req),
    .last  (last),
    .mask  (state == DONE),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // Request bit and write data of the currently granted requester.
  always_comb begin
    sel_req  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IW'(i)) begin
        sel_req  = req[i];
        sel_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Sequencer: grant, commit-or-abort, then re-arbitrate; all outputs registered.
  always_ff @(posedge c or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      gnt   <= '0;
      ack   <= 1'b0;
      q     <= '0;
      owner <= '0;
      busy  <= 1'b0;
      sel   <= '0;
      last  <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE, DONE: begin
          ack <= 1'b0;
          if (pick_valid) begin
            gnt   <= NREQ'(1) << pick_win;
            sel   <= pick_win;
            state <= GRANT;
            busy  <= 1'b1;
          end else begin
            gnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          gnt <= '0;
          if (sel_req) begin
            q     <= sel_data;
            owner <= sel;
            last  <= sel;
            ack   <= 1'b1;
            state <= DONE;
            busy  <= 1'b1;
          end else begin
            // Requester withdrew: drop the grant without writing or moving priority.
            ack   <= 1'b0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          gnt   <= '0;
          ack   <= 1'b0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: vector table, corner sequences, random vs model.
module tb_shared_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IW    = 2;

  logic                  c = 1'b0;
  logic                  rstn = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic [WIDTH-1:0]      q;
  logic [IW-1:0]         owner;
  logic                  busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic                  ack;
    logic [WIDTH-1:0]      q;
    logic [IW-1:0]         owner;
    logic                  busy;
  } vec_t;

  vec_t tbl[$];

  // Reference model state (transaction level)
  int               m_pend;
  int               m_last;
  int               m_owner;
  logic             m_ack;
  logic [WIDTH-1:0] m_q;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .c     (c),
    .rstn  (rstn),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  always #5 c = ~c;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic chk(input string name, input logic [NREQ-1:0] eg, input logic ea,
                     input logic [WIDTH-1:0] eq, input logic [IW-1:0] eo, input logic eb);
    tests++;
    if (gnt !== eg || ack !== ea || q !== eq || owner !== eo || busy !== eb) begin
      fails++;
      $display("FAIL %s: got gnt=%b ack=%b q=%h owner=%0d busy=%b, expected gnt=%b ack=%b q=%h owner=%0d busy=%b",
               name, gnt, ack, q, owner, busy, eg, ea, eq, eo, eb);
    end
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    req   = '0;
    wdata = '0;
    repeat (2) @(posedge c);
    #1;
    rstn = 1'b1;
    m_pend  = -1;
    m_last  = NREQ - 1;
    m_owner = 0;
    m_ack   = 1'b0;
    m_q     = '0;
  endtask

  // First requester set in r, searching from lst+1 with wraparound; -1 if none.
  function automatic int rr(input logic [NREQ-1:0] r, input int lst);
    for (int d = 1; d <= NREQ; d++) begin
      if (((r >> ((lst + d) % NREQ)) & 1) != 0) return (lst + d) % NREQ;
    end
    return -1;
  endfunction

  // Advance the model across one clock edge given the inputs seen at that edge.
  task automatic model_edge();
    logic [NREQ-1:0] r;
    if (m_pend >= 0) begin
      if (((req >> m_pend) & 1) != 0) begin
        m_q     = WIDTH'(wdata >> (m_pend * WIDTH));
        m_owner = m_pend;
        m_last  = m_pend;
        m_ack   = 1'b1;
      end else begin
        m_ack = 1'b0;
      end
      m_pend = -1;
    end else begin
      r = req;
      if (m_ack) r = r & ~(NREQ'(1) << m_last);
      m_ack  = 1'b0;
      m_pend = rr(r, m_last);
    end
  endtask

  initial begin
    int found;

    // ---------------- reset values ----------------
    do_reset();
    chk("reset_values", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

    // ---------------- vector table ----------------
    // fairness with all requesting
    tbl.push_back('{4'b1111, 32'h13121110, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 4'b0000, 1'b1, 8'h10, 2'd0, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 4'b0010, 1'b0, 8'h10, 2'd0, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 4'b0000, 1'b1, 8'h11, 2'd1, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 4'b0100, 1'b0, 8'h11, 2'd1, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 4'b0000, 1'b1, 8'h12, 2'd2, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 4'b1000, 1'b0, 8'h12, 2'd2, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 4'b0000, 1'b1, 8'h13, 2'd3, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 4'b0001, 1'b0, 8'h13, 2'd3, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 4'b0000, 1'b1, 8'h10, 2'd0, 1'b1});
    // idle, then single request from requester 1
    tbl.push_back('{4'b0000, 32'h00C0A500, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b0});
    tbl.push_back('{4'b0010, 32'h00C0A500, 4'b0010, 1'b0, 8'h10, 2'd0, 1'b1});
    tbl.push_back('{4'b0010, 32'h00C0A500, 4'b0000, 1'b1, 8'hA5, 2'd1, 1'b1});
    // req held one cycle past ack: masked in DONE, back to IDLE, then re-granted
    tbl.push_back('{4'b0010, 32'h00C0A500, 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b0});
    tbl.push_back('{4'b0010, 32'h00C0A500, 4'b0010, 1'b0, 8'hA5, 2'd1, 1'b1});
    // drop during GRANT: abort, no write
    tbl.push_back('{4'b0000, 32'h00C0A500, 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b0});
    // last still 1: requester 2 wins over 0
    tbl.push_back('{4'b0101, 32'h00C0A500, 4'b0100, 1'b0, 8'hA5, 2'd1, 1'b1});
    tbl.push_back('{4'b0101, 32'h00C0A500, 4'b0000, 1'b1, 8'hC0, 2'd2, 1'b1});
    tbl.push_back('{4'b0101, 32'h00C0A500, 4'b0001, 1'b0, 8'hC0, 2'd2, 1'b1});
    tbl.push_back('{4'b0000, 32'h00C0A500, 4'b0000, 1'b0, 8'hC0, 2'd2, 1'b0});

    foreach (tbl[i]) begin
      req   = tbl[i].req;
      wdata = tbl[i].wdata;
      tick();
      chk($sformatf("table_row%0d", i), tbl[i].gnt, tbl[i].ack, tbl[i].q, tbl[i].owner, tbl[i].busy);
    end

    // ---------------- abort from reset, then 0 wins with last=3 ----------------
    do_reset();
    req = 4'b0100; wdata = 32'h0000005A;
    tick(); chk("abort_grant2", 4'b0100, 1'b0, 8'h00, 2'd0, 1'b1);
    req = 4'b0000;
    tick(); chk("abort_drop", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    req = 4'b0101;
    tick(); chk("abort_then_grant0", 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1);
    tick(); chk("abort_then_commit0", 4'b0000, 1'b1, 8'h5A, 2'd0, 1'b1);

    // ---------------- priority wrap after requester 3 ----------------
    do_reset();
    req = 4'b1000; wdata = 32'h33000000;
    tick(); chk("wrap_grant3", 4'b1000, 1'b0, 8'h00, 2'd0, 1'b1);
    tick(); chk("wrap_commit3", 4'b0000, 1'b1, 8'h33, 2'd3, 1'b1);
    req = 4'b1001; wdata = 32'h33000044;
    tick(); chk("wrap_grant0", 4'b0001, 1'b0, 8'h33, 2'd3, 1'b1);
    tick(); chk("wrap_commit0", 4'b0000, 1'b1, 8'h44, 2'd0, 1'b1);
    tick(); chk("wrap_regrant3", 4'b1000, 1'b0, 8'h44, 2'd0, 1'b1);
    tick(); chk("wrap_recommit3", 4'b0000, 1'b1, 8'h33, 2'd3, 1'b1);

    // ---------------- asynchronous reset while in GRANT ----------------
    req = 4'b0010; wdata = 32'h0000A500;
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      tick();
      if (gnt === 4'b0010) found = 1;
    end
    tests++;
    if (found == 0) begin
      fails++;
      $display("FAIL reset_reach_grant: gnt=%b never reached expected 0010 within 8 cycles", gnt);
    end
    #2 rstn = 1'b0;
    #1 chk("reset_mid_grant", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    tick(); chk("reset_held", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req   = NREQ'($urandom);
      wdata = {$urandom};
      model_edge();
      tick();
      chk($sformatf("random_cycle%0d", n),
          (m_pend >= 0) ? (NREQ'(1) << m_pend) : NREQ'(0),
          m_ack, m_q, IW'(m_owner), (m_pend >= 0) || m_ack);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
